// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, bit positions, FSM states.
package uart_pkg;

  // Byte offsets of the registers inside the 16-byte window
  localparam logic [3:0] OffTxdata = 4'h0;
  localparam logic [3:0] OffRxdata = 4'h4;
  localparam logic [3:0] OffStatus = 4'h8;
  localparam logic [3:0] OffCtrl   = 4'hC;

  localparam int unsigned StatusTxFull     = 0;
  localparam int unsigned StatusTxEmpty    = 1;
  localparam int unsigned StatusRxEmpty    = 2;
  localparam int unsigned StatusRxFull     = 3;
  localparam int unsigned StatusRxOverrun  = 4;
  localparam int unsigned StatusFrameErr   = 5;
  localparam int unsigned StatusTxBusy     = 6;
  localparam int unsigned StatusTxOverflow = 7;

  localparam int unsigned CtrlTxEn     = 0;
  localparam int unsigned CtrlRxEn     = 1;
  localparam int unsigned CtrlLoopback = 2;

  localparam logic [2:0] CtrlReset = 3'b011;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage is not reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped UART with TX/RX FIFOs, sticky error flags, control register and loopback.
// Read_data is zero outside the register window so instances can be OR-combined.
module mmio_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 60000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0010,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        rx,
  output logic        tx
);

  localparam int unsigned Div      = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW     = $clog2(Div);
  localparam int unsigned CountW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DivLast  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Div / 2 - 1);

  // Bus decode
  logic [31:0] offset;
  logic        in_window;
  logic        wr_txdata, wr_status, wr_ctrl, rd_rxdata;

  assign offset    = Address - BASE_ADDR;
  assign in_window = (offset[31:4] == '0);
  assign wr_txdata = Write && in_window && (offset[3:0] == OffTxdata);
  assign wr_status = Write && in_window && (offset[3:0] == OffStatus);
  assign wr_ctrl   = Write && in_window && (offset[3:0] == OffCtrl);
  assign rd_rxdata = Read && in_window && (offset[3:0] == OffRxdata);

  logic [2:0] ctrl_q, ctrl_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       overflow_q, overflow_d;

  // FIFOs
  logic              tx_pop, tx_full, tx_empty;
  logic [7:0]        tx_dout;
  logic [CountW-1:0] tx_count;
  logic              rx_push, rx_full, rx_empty;
  logic [7:0]        rx_dout;
  logic [CountW-1:0] rx_count;
  logic [7:0]        rx_shift_q, rx_shift_d;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (tx_pop),
    .din   (Write_data[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rd_rxdata),
    .din   (rx_shift_q),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // TX FSM
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (ctrl_q[CtrlTxEn] && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_dout;
          tx_cnt_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == DivLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == DivLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == DivLast) begin
          tx_cnt_d   = '0;
          tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    // Line level is registered from the next state so tx never glitches
    unique case (tx_state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

  // RX path
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic            rx_in, rx_fall, frame_set;

  assign rx_in   = ctrl_q[CtrlLoopback] ? tx_q : rx_sync2_q;
  assign rx_fall = rx_prev_q && !rx_in;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (ctrl_q[CtrlRxEn] && rx_fall) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // Line back high at mid start bit: a glitch, not a frame
          rx_state_d = rx_in ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          rx_push    = rx_in;
          frame_set  = !rx_in;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_sync1_q <= rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_in;
    end
  end

  // Control and sticky flags; a new event wins over a same-cycle clear
  logic tx_drop, rx_drop;

  assign tx_drop = wr_txdata && tx_full && !tx_pop;
  assign rx_drop = rx_push && rx_full && !(rd_rxdata && !rx_empty);

  always_comb begin
    ctrl_d      = wr_ctrl ? Write_data[2:0] : ctrl_q;
    overrun_d   = (overrun_q && !(wr_status && Write_data[StatusRxOverrun])) || rx_drop;
    frame_err_d = (frame_err_q && !(wr_status && Write_data[StatusFrameErr])) || frame_set;
    overflow_d  = (overflow_q && !(wr_status && Write_data[StatusTxOverflow])) || tx_drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= CtrlReset;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // Read mux
  logic [31:0] status;

  assign status = {16'b0, 8'(rx_count), overflow_q, (tx_state_q != TxIdle), frame_err_q,
                   overrun_q, rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    Read_data = '0;
    if (Read && in_window) begin
      case (offset[3:0])
        OffRxdata: Read_data = rx_empty ? 32'b0 : {24'b0, rx_dout};
        OffStatus: Read_data = status;
        OffCtrl:   Read_data = {29'b0, ctrl_q};
        default:   Read_data = '0;
      endcase
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{Write_data[31:8], Write_data[6], Write_data[3], tx_count};

endmodule

// File: tb/tb_mmio_uart.sv
// Directed self-checking bench for mmio_uart at DIV=4, 16-entry FIFOs.
module tb_mmio_uart;

  localparam int unsigned Div = 4;
  localparam logic [31:0] Base       = 32'h4000_0010;
  localparam logic [31:0] AddrTx     = Base;
  localparam logic [31:0] AddrRx     = Base + 32'd4;
  localparam logic [31:0] AddrStatus = Base + 32'd8;
  localparam logic [31:0] AddrCtrl   = Base + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic [31:0] Read_data;
  logic        rx = 1'b1;
  logic        tx;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  mmio_uart #(
    .CLK_FREQ   (1000000),
    .BAUD_RATE  (250000),
    .BASE_ADDR  (Base),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Read       (Read),
    .Write      (Write),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .rx         (rx),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Address = a; Write_data = d; Write = 1'b1;
    @(posedge clk);
    #1;
    Write = 1'b0; Address = '0; Write_data = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    Address = a; Read = 1'b1;
    #1;
    d = Read_data;
    @(posedge clk);
    #1;
    Read = 1'b0; Address = '0;
  endtask

  // Decode one frame from tx, sampling mid-bit; ok=0 on timeout or bad stop bit
  task automatic capture_tx(output logic [7:0] b, output logic ok);
    int unsigned waited = 0;
    ok = 1'b0;
    b  = '0;
    @(negedge clk);
    while (tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (tx === 1'b0) begin
      repeat (6) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        b[j] = tx;
        if (j < 7) repeat (Div) @(negedge clk);
      end
      repeat (Div) @(negedge clk);
      ok = (tx === 1'b1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (Div) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx = b[j];
      repeat (Div) @(negedge clk);
    end
    rx = stop;
    repeat (Div) @(negedge clk);
    rx = 1'b1;
    repeat (Div) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL reset_status: got %h want %h", d, 32'h6); end
    bus_read(AddrCtrl, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL reset_ctrl: got %h want %h", d, 32'h3); end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    bus_read(32'h4000_0020, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_above: got %h want 0", d); end
    bus_read(32'h4000_000C, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_below: got %h want 0", d); end
    bus_read(AddrRx, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read: got %h want 0", d); end
    @(negedge clk);
    Address = AddrCtrl;
    #1;
    n_checks++;
    if (Read_data !== 32'h0) begin
      n_fail++; $display("FAIL no_read_strobe: got %h want 0", Read_data);
    end
    Address = '0;
  endtask

  task automatic test_tx_frame();
    logic [7:0]  b = 8'h55;
    logic        exp_tx, exp_busy;
    logic [31:0] d;
    bus_write(AddrTx, {24'b0, b});
    Read = 1'b1; Address = AddrStatus;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      if (k == 0)       exp_tx = 1'b1;
      else if (k <= 4)  exp_tx = 1'b0;
      else if (k <= 36) exp_tx = b[(k - 5) / 4];
      else              exp_tx = 1'b1;
      exp_busy = (k >= 1 && k <= 40);
      n_checks++;
      if (tx !== exp_tx) begin
        n_fail++; $display("FAIL tx_bit cycle %0d: got %b want %b", k, tx, exp_tx);
      end
      n_checks++;
      if (Read_data[6] !== exp_busy) begin
        n_fail++; $display("FAIL tx_busy cycle %0d: got %b want %b", k, Read_data[6], exp_busy);
      end
    end
    Read = 1'b0; Address = '0;
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL tx_done_status: got %h want %h", d, 32'h6); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    bus_write(AddrCtrl, 32'h7);
    bus_write(AddrTx, 32'hA3);
    repeat (50) @(posedge clk);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h0000_0102) begin
      n_fail++; $display("FAIL loop_status: got %h want %h", d, 32'h0000_0102);
    end
    bus_read(AddrRx, d);
    n_checks++;
    if (d !== 32'h0000_00A3) begin
      n_fail++; $display("FAIL loop_rxdata: got %h want %h", d, 32'h0000_00A3);
    end
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL loop_popped: got %h want %h", d, 32'h6); end
    bus_write(AddrCtrl, 32'h3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  b, exp_b;
    logic        ok;
    bus_write(AddrCtrl, 32'h2);
    for (int i = 0; i < 17; i++) bus_write(AddrTx, 32'(8'(i * 37 + 5)));
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h85) begin n_fail++; $display("FAIL ovf_status: got %h want %h", d, 32'h85); end
    bus_write(AddrStatus, 32'h80);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h05) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", d, 32'h05); end
    bus_write(AddrCtrl, 32'h3);
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(i * 37 + 5);
      capture_tx(b, ok);
      n_checks++;
      if (!ok || b !== exp_b) begin
        n_fail++; $display("FAIL tx_frame %0d: got %h ok=%b want %h", i, b, ok, exp_b);
      end
    end
    repeat (10) @(posedge clk);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL ovf_drained: got %h want %h", d, 32'h6); end
  endtask

  task automatic test_frame_error();
    logic [31:0] d;
    send_rx(8'h3C, 1'b0);
    repeat (4) @(posedge clk);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h26) begin n_fail++; $display("FAIL frame_err: got %h want %h", d, 32'h26); end
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (50) @(posedge clk);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h26) begin n_fail++; $display("FAIL glitch: got %h want %h", d, 32'h26); end
    bus_write(AddrStatus, 32'h20);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL frame_clear: got %h want %h", d, 32'h6); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  exp_b;
    for (int i = 0; i < 17; i++) send_rx(8'(i * 13 + 7), 1'b1);
    repeat (4) @(posedge clk);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h101A) begin n_fail++; $display("FAIL overrun: got %h want %h", d, 32'h101A); end
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(i * 13 + 7);
      bus_read(AddrRx, d);
      n_checks++;
      if (d !== {24'b0, exp_b}) begin
        n_fail++; $display("FAIL rx_byte %0d: got %h want %h", i, d, {24'b0, exp_b});
      end
    end
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h16) begin n_fail++; $display("FAIL rx_drained: got %h want %h", d, 32'h16); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int unsigned lows = 0;
    bus_write(AddrTx, 32'hF0);
    repeat (12) @(negedge clk);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h56) begin n_fail++; $display("FAIL mid_frame: got %h want %h", d, 32'h56); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_abort_tx: got %b want 1", tx); end
    reset = 1'b0;
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL reset_status2: got %h want %h", d, 32'h6); end
    bus_read(AddrCtrl, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL reset_ctrl2: got %h want %h", d, 32'h3); end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) begin n_fail++; $display("FAIL post_reset_idle: got %0d low cycles want 0", lows); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_back_to_back();
    test_frame_error();
    test_rx_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped UART peripheral on the CPU device bus (Read/Write/Address/Write_data/Read_data).
- Parametrised successor to the fixed-rate device UART.
- Adds configurable baud rate, base address and FIFO depth, separate TX/RX FIFOs, sticky error flags, a control register and internal loopback.
- Read_data is zero when the address is not decoded, so several instances can be OR-combined onto one bus.

Parameters:
- CLK_FREQ, 60000000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate; DIV = CLK_FREQ/BAUD_RATE, truncated; DIV >= 4 required.
- BASE_ADDR, 32'h4000_0010: word-aligned base of the 4-register window.
- FIFO_DEPTH, 16: entries per FIFO; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- Read  in  1  bus read strobe.
- Write  in  1  bus write strobe.
- Address  in  32  byte address.
- Write_data  in  32  write data.
- Read_data  out  32  combinational read data.
- rx  in  1  serial input, asynchronous.
- tx  out  1  serial output, idle high.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - +0 TXDATA, W: push Write_data[7:0] into the TX FIFO.
  - +4 RXDATA, R: {24'b0, head byte}; pops on the clock edge when Read is high.
  - +8 STATUS, R/W1C.
  - +C CTRL, R/W, bits [2:0].
- STATUS bits:
  - 0 tx_full; 1 tx_empty; 2 rx_empty; 3 rx_full.
  - 4 rx_overrun (sticky); 5 frame_err (sticky); 6 tx_busy; 7 tx_overflow (sticky).
  - [15:8] rx_count, zero-extended.
  - Writing 1 to bit 4, 5 or 7 clears that bit. Other bits are read-only.
- CTRL bits: 0 tx_en; 1 rx_en; 2 loopback. Reset value 3'b011.
- Read_data:
  - Combinational from Address when Read=1 and Address is inside the window.
  - 0 otherwise.
  - Reading RXDATA when the RX FIFO is empty returns 0 and does not pop.
- Reset values:
  - tx=1; FIFOs empty; sticky flags 0; CTRL=3'b011; both FSMs IDLE; baud counters 0.
  - STATUS reads 32'h0000_0006.
  - Reset mid-frame aborts the frame; tx is 1 the following cycle.
- FIFOs:
  - Push is accepted if not full, or if a pop happens in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - A TXDATA write when full and not popping is dropped and sets tx_overflow.
  - An RX byte arriving when RX is full is dropped and sets rx_overrun.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if tx_en=1 and TX not empty, pop and latch the byte, go to START on the next edge.
  - START: tx=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - STOP: tx=1 for DIV cycles, then IDLE.
  - Frame = 10*DIV cycles; tx_busy=1 outside IDLE.
  - Clearing tx_en mid-frame finishes the current frame and does not start the next.
- RX path:
  - rx passes through a 2-FF synchroniser.
  - Effective input = tx when loopback=1, else the synchronised rx.
  - In loopback, tx is still driven externally.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge with rx_en=1 goes to START.
  - START: wait DIV/2 cycles and sample. If high, it is a false start: return to IDLE with nothing reported.
  - DATA: sample every DIV cycles, 8 bits, LSB first.
  - STOP: sample after DIV cycles. If 1, push the byte. If 0, set frame_err and discard the byte. Return to IDLE.
- Simultaneous events:
  - A W1C write in the same cycle as a new sticky event leaves the flag set (set wins).
  - A bus pop in the same cycle as an RX push is legal.

Decomposition:
- Package uart_pkg:
  - Register offset constants.
  - STATUS/CTRL bit index constants.
  - TX and RX state enums.
  - CTRL reset constant.
- Sub-module sync_fifo, parametrised by WIDTH and DEPTH.
  - Ports: push, pop, din, dout (head, combinational), full, empty, count.
  - Instantiated twice (TX and RX).

Test Plan:
- Bench uses CLK_FREQ=1000000, BAUD_RATE=250000 (DIV=4), FIFO_DEPTH=16.
- Reset: read STATUS -> 32'h0000_0006; read CTRL -> 32'h3; tx=1; read of an unmapped address -> 0.
- Write 0x55 to TXDATA: tx low for 4 cycles starting 1 cycle after the write, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop high; tx_busy=1 for 40 cycles, then STATUS=0x06.
- Loopback: CTRL=0x7, write 0xA3, wait 50 cycles -> rx_count=1, rx_empty=0; read RXDATA -> 32'h0000_00A3; then STATUS bit2=1.
- Overflow: CTRL=0x2, 17 back-to-back TXDATA writes -> tx_full=1, tx_overflow=1, count 16. Write STATUS 0x80 -> bit7 cleared. CTRL=0x3 -> 16 frames sent, in order.
- Frame error: drive rx with 0x3C and stop bit=0 -> frame_err=1, rx_empty stays 1. A 2-cycle low glitch -> no change. Write STATUS 0x20 -> cleared.
- RX overrun: send 17 frames without reading -> rx_full=1, rx_overrun=1, first 16 bytes read back intact. Reset asserted mid-TX frame -> tx=1 next cycle, STATUS=0x06.
